// File: rtl/mips_pkg.sv
// Shared constants for the MIPS fetch path: next-PC operation encodings,
// pending-redirect state type and default address/vector values.
package mips_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  typedef enum logic {
    PEND_IDLE = 1'b0,
    PEND_HELD = 1'b1
  } pend_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target (branch/jump/jr) and link value for the D-stage PC.
// Zero latency; no flow control.
module pc_target_calc
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [15:0]       imm16,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc8_d
);

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] hi_mask;

  assign pc4     = pc_d + ADDR_W'(4);
  assign pc8_d   = pc_d + ADDR_W'(8);
  assign br_off  = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
  assign br_target = pc4 + br_off;

  // Mask form keeps the region bits valid even when ADDR_W is exactly 28.
  assign hi_mask  = ~ADDR_W'(28'hFFF_FFFF);
  assign j_target = (pc4 & hi_mask) | ADDR_W'({imm26, 2'b00});

  always_comb begin
    target = pc4;
    case (op)
      NPC_BR:  target = br_target;
      NPC_J:   target = j_target;
      NPC_JR:  target = rs_val;
      default: target = pc4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register: one-edge update on advance, exc/eret load regardless of hold,
// redirects arriving while held are parked in a pending latch and applied on the next advance.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              fetch_ready,
  input  logic              redir_valid,
  input  logic [1:0]        redir_op,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [15:0]       imm16,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc_f,
  output logic [ADDR_W-1:0] pc8_d,
  output logic              fetch_valid,
  output logic              adel_f,
  output logic              pend_valid
);

  pend_state_e       pend_state, pend_state_nxt;
  logic [ADDR_W-1:0] pend_target, pend_target_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] redir_target;
  logic              pc_load;
  logic              advance;
  logic              redir_take;

  pc_target_calc #(.ADDR_W(ADDR_W)) u_target (
    .op     (redir_op),
    .pc_d   (pc_d),
    .imm16  (imm16),
    .imm26  (imm26),
    .rs_val (rs_val),
    .target (redir_target),
    .pc8_d  (pc8_d)
  );

  assign advance    = !stall && fetch_ready;
  assign redir_take = redir_valid && (redir_op != NPC_SEQ);
  assign pend_valid = (pend_state == PEND_HELD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f        <= RESET_PC;
      adel_f      <= 1'b0;
      fetch_valid <= 1'b0;
      pend_state  <= PEND_IDLE;
      pend_target <= '0;
    end else begin
      fetch_valid <= 1'b1;
      pend_state  <= pend_state_nxt;
      pend_target <= pend_target_nxt;
      if (pc_load) begin
        pc_f   <= pc_nxt;
        adel_f <= |pc_nxt[1:0];
      end
    end
  end

  always_comb begin
    pc_nxt          = pc_f + ADDR_W'(4);
    pc_load         = 1'b0;
    pend_state_nxt  = pend_state;
    pend_target_nxt = pend_target;
    if (exc_req) begin
      pc_nxt         = EXC_PC;
      pc_load        = 1'b1;
      pend_state_nxt = PEND_IDLE;
    end else if (eret_req) begin
      pc_nxt         = epc;
      pc_load        = 1'b1;
      pend_state_nxt = PEND_IDLE;
    end else if (advance) begin
      pc_load = 1'b1;
      // A parked redirect outranks a new one; the pipeline never issues both.
      if (pend_state == PEND_HELD) begin
        pc_nxt         = pend_target;
        pend_state_nxt = PEND_IDLE;
      end else if (redir_take) begin
        pc_nxt = redir_target;
      end
    end else if (redir_take) begin
      pend_state_nxt  = PEND_HELD;
      pend_target_nxt = redir_target;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        fetch_ready;
  logic        redir_valid;
  logic [1:0]  redir_op;
  logic [31:0] pc_d;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_val;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_f;
  logic [31:0] pc8_d;
  logic        fetch_valid;
  logic        adel_f;
  logic        pend_valid;

  int n_assert = 0;
  int n_fail   = 0;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .fetch_ready (fetch_ready),
    .redir_valid (redir_valid),
    .redir_op    (redir_op),
    .pc_d        (pc_d),
    .imm16       (imm16),
    .imm26       (imm26),
    .rs_val      (rs_val),
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
    .pc_f        (pc_f),
    .pc8_d       (pc8_d),
    .fetch_valid (fetch_valid),
    .adel_f      (adel_f),
    .pend_valid  (pend_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A new redirect colliding with a parked one under advance is illegal pipeline behaviour.
  always @(negedge clk) begin
    if (!reset && redir_valid && redir_op != 2'b00 && pend_valid && !stall && fetch_ready
        && !exc_req && !eret_req) begin
      n_fail++;
      $error("FAIL redir_pend_collide: observed redir with pend_valid=%b expected none", pend_valid);
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; fetch_ready = 1'b1;
    redir_valid = 1'b0; redir_op = 2'b00; pc_d = '0; imm16 = '0; imm26 = '0;
    rs_val = '0; exc_req = 1'b0; eret_req = 1'b0; epc = '0;

    #1;
    chk("rst_pc", pc_f, 32'h3000);
    chk("rst_fv", {31'b0, fetch_valid}, 32'd0);
    chk("rst_pend", {31'b0, pend_valid}, 32'd0);
    chk("rst_adel", {31'b0, adel_f}, 32'd0);

    #11 reset = 1'b0;
    #1;
    chk("first_pc", pc_f, 32'h3000);
    chk("first_fv", {31'b0, fetch_valid}, 32'd0);
    tick();
    chk("seq1_pc", pc_f, 32'h3004);
    chk("seq1_fv", {31'b0, fetch_valid}, 32'd1);
    tick();
    chk("seq2_pc", pc_f, 32'h3008);

    // Backward branch onto itself: 3004 + 4 - 4
    pc_d = 32'h3004; imm16 = 16'hFFFF; redir_op = 2'b01; redir_valid = 1'b1;
    #1;
    chk("br_pc8", pc8_d, 32'h300C);
    tick();
    chk("br_pc", pc_f, 32'h3004);
    redir_valid = 1'b0;

    // Jump parked by backpressure: target {0, C40, 00} = 3100
    pc_d = 32'h3010; imm26 = 26'h0000C40; redir_op = 2'b10; redir_valid = 1'b1;
    fetch_ready = 1'b0;
    tick();
    chk("jhold1_pc", pc_f, 32'h3004);
    chk("jhold1_pend", {31'b0, pend_valid}, 32'd1);
    redir_valid = 1'b0;
    tick();
    tick();
    chk("jhold3_pc", pc_f, 32'h3004);
    chk("jhold3_pend", {31'b0, pend_valid}, 32'd1);
    fetch_ready = 1'b1;
    tick();
    chk("jrel_pc", pc_f, 32'h3100);
    chk("jrel_pend", {31'b0, pend_valid}, 32'd0);
    tick();
    chk("jseq_pc", pc_f, 32'h3104);

    // Unaligned jr passes through unmodified
    rs_val = 32'h3001; redir_op = 2'b11; redir_valid = 1'b1;
    tick();
    chk("jr_pc", pc_f, 32'h3001);
    chk("jr_adel", {31'b0, adel_f}, 32'd1);
    redir_valid = 1'b0;
    tick();
    chk("jrseq_pc", pc_f, 32'h3005);
    chk("jrseq_adel", {31'b0, adel_f}, 32'd1);

    // Op 00 with valid is ignored
    redir_op = 2'b00; redir_valid = 1'b1; rs_val = 32'h5000;
    tick();
    chk("op00_pc", pc_f, 32'h3009);
    redir_valid = 1'b0;

    // Park a forward branch under stall: 3000 + 4 + 0x40 = 3044
    stall = 1'b1; pc_d = 32'h3000; imm16 = 16'h0010; redir_op = 2'b01; redir_valid = 1'b1;
    tick();
    chk("stall_pc", pc_f, 32'h3009);
    chk("stall_pend", {31'b0, pend_valid}, 32'd1);
    redir_valid = 1'b0;
    exc_req = 1'b1;
    tick();
    chk("exc_pc", pc_f, 32'h4180);
    chk("exc_pend", {31'b0, pend_valid}, 32'd0);
    chk("exc_adel", {31'b0, adel_f}, 32'd0);
    exc_req = 1'b0;
    eret_req = 1'b1; epc = 32'h3020;
    tick();
    chk("eret_pc", pc_f, 32'h3020);
    eret_req = 1'b0; stall = 1'b0;
    tick();
    chk("eret_seq_pc", pc_f, 32'h3024);

    // Simultaneous exc and eret: exception wins
    exc_req = 1'b1; eret_req = 1'b1; epc = 32'h3300;
    tick();
    chk("exc_eret_pc", pc_f, 32'h4180);
    exc_req = 1'b0; eret_req = 1'b0;

    // Park a jump, then reset asynchronously between edges
    fetch_ready = 1'b0; pc_d = 32'h3010; imm26 = 26'h0000C40; redir_op = 2'b10; redir_valid = 1'b1;
    tick();
    chk("pre_rst_pend", {31'b0, pend_valid}, 32'd1);
    redir_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("arst_pc", pc_f, 32'h3000);
    chk("arst_pend", {31'b0, pend_valid}, 32'd0);
    chk("arst_fv", {31'b0, fetch_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
